// File: rtl/sd_pkg.sv
// Shared constants and types for the SDRAM controller front-end blocks.
package sd_pkg;

    localparam int SD_ADDR_W = 20;
    localparam int SD_DATA_W = 16;

    localparam logic [1:0] ARB_IDLE      = 2'd0;
    localparam logic [1:0] ARB_REQ       = 2'd1;
    localparam logic [1:0] ARB_WAIT_DATA = 2'd2;

    typedef enum logic {
        SD_OP_READ  = 1'b0,
        SD_OP_WRITE = 1'b1
    } sd_op_t;

endpackage

// File: rtl/sd_rr_picker.sv
// Combinational round-robin picker: first pending client after i_last, wrapping.
module sd_rr_picker #(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] i_pending,
    input  logic [IDX_W-1:0]       i_last,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_any
);

    // Walk offsets from farthest to nearest so the nearest pending client wins.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int off = NUM_CLIENTS; off >= 1; off--) begin
            if (i_pending[(int'(i_last) + off) % NUM_CLIENTS]) begin
                o_idx = IDX_W'((int'(i_last) + off) % NUM_CLIENTS);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_request_arbiter.sv
// Round-robin front-end sharing one sd_controller request port among clients.
// Optional read watchdog enabled by defining SD_ARB_TIMEOUT_EN.
//
//   state          | meaning
//   ARB_IDLE       | no transaction held; arbitrate among pending clients
//   ARB_REQ        | latched request driven to controller until matching grant
//   ARB_WAIT_DATA  | read granted; waiting for controller data valid
module sd_request_arbiter
    import sd_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int ADDR_W         = SD_ADDR_W,
    parameter int DATA_W         = SD_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          i_Reset_n,
    input  logic [NUM_CLIENTS-1:0]        i_Client_Read_Request,
    input  logic [NUM_CLIENTS-1:0]        i_Client_Write_Request,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] i_Client_Address,
    input  logic [NUM_CLIENTS*DATA_W-1:0] i_Client_Write_Data,
    output logic [NUM_CLIENTS-1:0]        o_Client_Grant,
    output logic [NUM_CLIENTS-1:0]        o_Client_Data_Valid,
    output logic [DATA_W-1:0]             o_Read_Data,
    output logic                          o_Timeout,
    output logic                          o_Busy,
    output logic                          o_Ctl_Read_Request,
    output logic                          o_Ctl_Write_Request,
    output logic [ADDR_W-1:0]             o_Ctl_Read_Address,
    output logic [ADDR_W-1:0]             o_Ctl_Write_Address,
    output logic [DATA_W-1:0]             o_Ctl_Write_Data,
    input  logic                          i_Ctl_Read_Grant,
    input  logic                          i_Ctl_Write_Grant,
    input  logic                          i_Ctl_Data_Valid,
    input  logic [DATA_W-1:0]             i_Ctl_Read_Data
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    sd_op_t                 op_q, op_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [NUM_CLIENTS-1:0] dv_q, dv_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   timeout_q, timeout_d;
`endif

    logic [NUM_CLIENTS-1:0] pending;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   match_grant;

    assign pending = i_Client_Read_Request | i_Client_Write_Request;

    sd_rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .i_pending (pending),
        .i_last    (last_q),
        .o_idx     (pick_idx),
        .o_any     (pick_any)
    );

    assign match_grant = (op_q == SD_OP_WRITE) ? i_Ctl_Write_Grant : i_Ctl_Read_Grant;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        grant_d = '0;
        dv_d    = '0;
        rdata_d = rdata_q;
`ifdef SD_ARB_TIMEOUT_EN
        tmr_d     = tmr_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    idx_d   = pick_idx;
                    op_d    = i_Client_Write_Request[pick_idx] ? SD_OP_WRITE : SD_OP_READ;
                    addr_d  = i_Client_Address[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d = i_Client_Write_Data[int'(pick_idx)*DATA_W +: DATA_W];
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (match_grant) begin
                    grant_d = NUM_CLIENTS'(1) << idx_q;
                    last_d  = idx_q;
                    state_d = (op_q == SD_OP_WRITE) ? ARB_IDLE : ARB_WAIT_DATA;
`ifdef SD_ARB_TIMEOUT_EN
                    tmr_d   = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                end
            end
            ARB_WAIT_DATA: begin
                if (i_Ctl_Data_Valid) begin
                    rdata_d = i_Ctl_Read_Data;
                    dv_d    = NUM_CLIENTS'(1) << idx_q;
                    state_d = ARB_IDLE;
                end
`ifdef SD_ARB_TIMEOUT_EN
                // Terminal count: expire on the cycle the count would reach the limit.
                else if (tmr_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = ARB_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= ARB_IDLE;
            last_q  <= IDX_W'(NUM_CLIENTS - 1);
            idx_q   <= '0;
            op_q    <= SD_OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            grant_q <= '0;
            dv_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            grant_q <= grant_d;
            dv_q    <= dv_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_Timeout = timeout_q;
`else
    assign o_Timeout = 1'b0;
`endif

    // Controller-side lines decode straight from flops so reset drops them at once.
    assign o_Ctl_Write_Request = (state_q == ARB_REQ) && (op_q == SD_OP_WRITE);
    assign o_Ctl_Read_Request  = (state_q == ARB_REQ) && (op_q == SD_OP_READ);
    assign o_Ctl_Write_Address = o_Ctl_Write_Request ? addr_q  : '0;
    assign o_Ctl_Read_Address  = o_Ctl_Read_Request  ? addr_q  : '0;
    assign o_Ctl_Write_Data    = o_Ctl_Write_Request ? wdata_q : '0;

    assign o_Busy              = (state_q != ARB_IDLE);
    assign o_Client_Grant      = grant_q;
    assign o_Client_Data_Valid = dv_q;
    assign o_Read_Data         = rdata_q;

endmodule

// File: tb/tb_sd_request_arbiter.sv
// Self-checking bench for sd_request_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_sd_request_arbiter;

    localparam int NC = 4;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NC-1:0]   c_rd = '0, c_wr = '0;
    logic [NC*AW-1:0] c_addr = '0;
    logic [NC*DW-1:0] c_wdata = '0;
    logic            ctl_rg = 1'b0, ctl_wg = 1'b0, ctl_dv = 1'b0;
    logic [DW-1:0]   ctl_rdata = '0;

    logic [NC-1:0]   o_Client_Grant, o_Client_Data_Valid;
    logic [DW-1:0]   o_Read_Data, o_Ctl_Write_Data;
    logic            o_Timeout, o_Busy, o_Ctl_Read_Request, o_Ctl_Write_Request;
    logic [AW-1:0]   o_Ctl_Read_Address, o_Ctl_Write_Address;

    int vectors = 0;
    int miscompares = 0;

    sd_request_arbiter #(
        .NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                    (clk),
        .i_Reset_n              (rst_n),
        .i_Client_Read_Request  (c_rd),
        .i_Client_Write_Request (c_wr),
        .i_Client_Address       (c_addr),
        .i_Client_Write_Data    (c_wdata),
        .o_Client_Grant         (o_Client_Grant),
        .o_Client_Data_Valid    (o_Client_Data_Valid),
        .o_Read_Data            (o_Read_Data),
        .o_Timeout              (o_Timeout),
        .o_Busy                 (o_Busy),
        .o_Ctl_Read_Request     (o_Ctl_Read_Request),
        .o_Ctl_Write_Request    (o_Ctl_Write_Request),
        .o_Ctl_Read_Address     (o_Ctl_Read_Address),
        .o_Ctl_Write_Address    (o_Ctl_Write_Address),
        .o_Ctl_Write_Data       (o_Ctl_Write_Data),
        .i_Ctl_Read_Grant       (ctl_rg),
        .i_Ctl_Write_Grant      (ctl_wg),
        .i_Ctl_Data_Valid       (ctl_dv),
        .i_Ctl_Read_Data        (ctl_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        c_rd = '0; c_wr = '0;
        ctl_rg = 1'b0; ctl_wg = 1'b0; ctl_dv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_client(input int k, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        c_rd[k] = rd;
        c_wr[k] = wr;
        c_addr[k*AW +: AW] = a;
        c_wdata[k*DW +: DW] = d;
    endtask

    // First pending client strictly after 'last', wrapping; -1 when none pending.
    function automatic int rr_pick(input logic [NC-1:0] pend, input int last);
        for (int off = 1; off <= NC; off++) begin
            int c;
            c = (last + off) % NC;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({o_Client_Grant, o_Client_Data_Valid, o_Timeout, o_Busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_status: got gnt=%b dv=%b to=%b busy=%b, want all 0",
                     o_Client_Grant, o_Client_Data_Valid, o_Timeout, o_Busy);
        end
        vectors++;
        if ({o_Ctl_Read_Request, o_Ctl_Write_Request, o_Ctl_Read_Address,
             o_Ctl_Write_Address, o_Ctl_Write_Data, o_Read_Data} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctl: got rr=%b wr=%b ra=%h wa=%h wd=%h rd=%h, want all 0",
                     o_Ctl_Read_Request, o_Ctl_Write_Request, o_Ctl_Read_Address,
                     o_Ctl_Write_Address, o_Ctl_Write_Data, o_Read_Data);
        end
    endtask

    task automatic test_single_write();
        set_client(2, 1'b0, 1'b1, 20'h00001, 16'd12);
        tick();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({o_Ctl_Write_Request, o_Ctl_Read_Request} !== 2'b10 ||
                o_Ctl_Write_Address !== 20'h00001 || o_Ctl_Write_Data !== 16'd12 ||
                o_Ctl_Read_Address !== 20'h0) begin
                miscompares++;
                $display("FAIL single_write_req: got wr=%b rd=%b wa=%h wd=%h ra=%h, want 1 0 00001 000c 00000",
                         o_Ctl_Write_Request, o_Ctl_Read_Request, o_Ctl_Write_Address,
                         o_Ctl_Write_Data, o_Ctl_Read_Address);
            end
            vectors++;
            if (o_Client_Grant !== 4'b0000) begin
                miscompares++;
                $display("FAIL single_write_early_grant: got %b, want 0000", o_Client_Grant);
            end
            ctl_rg = (i == 1);
            tick();
        end
        ctl_wg = 1'b1;
        tick();
        ctl_wg = 1'b0;
        vectors++;
        if (o_Client_Grant !== 4'b0100 || o_Ctl_Write_Request !== 1'b0) begin
            miscompares++;
            $display("FAIL single_write_grant: got gnt=%b wr=%b, want 0100 0",
                     o_Client_Grant, o_Ctl_Write_Request);
        end
        set_client(2, 1'b0, 1'b0, 20'h0, 16'h0);
        tick();
        vectors++;
        if (o_Client_Grant !== 4'b0000 || o_Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_write_after: got gnt=%b busy=%b, want 0000 0",
                     o_Client_Grant, o_Busy);
        end
    endtask

    task automatic test_read_return();
        set_client(1, 1'b1, 1'b0, 20'h00ABC, 16'h0);
        tick();
        vectors++;
        if ({o_Ctl_Read_Request, o_Ctl_Write_Request} !== 2'b10 ||
            o_Ctl_Read_Address !== 20'h00ABC || o_Ctl_Write_Address !== 20'h0) begin
            miscompares++;
            $display("FAIL read_req: got rr=%b wr=%b ra=%h wa=%h, want 1 0 00abc 00000",
                     o_Ctl_Read_Request, o_Ctl_Write_Request, o_Ctl_Read_Address,
                     o_Ctl_Write_Address);
        end
        ctl_rg = 1'b1;
        tick();
        ctl_rg = 1'b0;
        set_client(1, 1'b0, 1'b0, 20'h0, 16'h0);
        vectors++;
        if (o_Client_Grant !== 4'b0010 || o_Ctl_Read_Request !== 1'b0 || o_Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL read_grant: got gnt=%b rr=%b busy=%b, want 0010 0 1",
                     o_Client_Grant, o_Ctl_Read_Request, o_Busy);
        end
        tick();
        tick();
        vectors++;
        if (o_Client_Data_Valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL read_early_dv: got %b, want 0000", o_Client_Data_Valid);
        end
        ctl_dv = 1'b1;
        ctl_rdata = 16'h1234;
        tick();
        ctl_dv = 1'b0;
        ctl_rdata = 16'hDEAD;
        vectors++;
        if (o_Read_Data !== 16'h1234 || o_Client_Data_Valid !== 4'b0010) begin
            miscompares++;
            $display("FAIL read_data: got data=%h dv=%b, want 1234 0010",
                     o_Read_Data, o_Client_Data_Valid);
        end
        tick();
        vectors++;
        if (o_Read_Data !== 16'h1234 || o_Client_Data_Valid !== 4'b0000 || o_Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL read_hold: got data=%h dv=%b busy=%b, want 1234 0000 0",
                     o_Read_Data, o_Client_Data_Valid, o_Busy);
        end
    endtask

    task automatic test_round_robin();
        int n, budget;
        logic [NC-1:0] exp_g;
        do_reset();
        for (int k = 0; k < NC; k++) set_client(k, 1'b0, 1'b1, AW'(32'h100 + k), DW'(32'h50 + k));
        n = 0;
        budget = 0;
        while (n < 5 && budget < 200) begin
            tick();
            budget++;
            ctl_wg = 1'b0;
            exp_g = 4'b0001 << (n % NC);
            if (o_Client_Grant !== 4'b0000) begin
                vectors++;
                if (o_Client_Grant !== exp_g) begin
                    miscompares++;
                    $display("FAIL rr_order[%0d]: got %b, want %b", n, o_Client_Grant, exp_g);
                end
                n++;
            end
            if (o_Ctl_Write_Request === 1'b1) begin
                vectors++;
                if (o_Ctl_Write_Address !== AW'(32'h100 + (n % NC))) begin
                    miscompares++;
                    $display("FAIL rr_addr[%0d]: got %h, want %h", n, o_Ctl_Write_Address,
                             AW'(32'h100 + (n % NC)));
                end
            end
            ctl_wg = o_Ctl_Write_Request;
        end
        ctl_wg = 1'b0;
        c_wr = '0;
        if (n < 5) begin
            vectors++;
            miscompares++;
            $display("FAIL rr_budget: got %0d grants, want 5", n);
        end
        tick();
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_client(0, 1'b1, 1'b1, 20'h00777, 16'h0777);
        tick();
        vectors++;
        if ({o_Ctl_Write_Request, o_Ctl_Read_Request} !== 2'b10 ||
            o_Ctl_Write_Address !== 20'h00777 || o_Ctl_Write_Data !== 16'h0777) begin
            miscompares++;
            $display("FAIL simul_req: got wr=%b rr=%b wa=%h wd=%h, want 1 0 00777 0777",
                     o_Ctl_Write_Request, o_Ctl_Read_Request, o_Ctl_Write_Address, o_Ctl_Write_Data);
        end
        ctl_wg = 1'b1;
        tick();
        ctl_wg = 1'b0;
        set_client(0, 1'b0, 1'b0, 20'h0, 16'h0);
        vectors++;
        if (o_Client_Grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL simul_grant: got %b, want 0001", o_Client_Grant);
        end
        tick();
        vectors++;
        if ({o_Busy, o_Ctl_Read_Request} !== 2'b00) begin
            miscompares++;
            $display("FAIL simul_no_read: got busy=%b rr=%b, want 0 0", o_Busy, o_Ctl_Read_Request);
        end
    endtask

`ifdef SD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        set_client(3, 1'b1, 1'b0, 20'h33333, 16'h0);
        tick();
        ctl_rg = 1'b1;
        tick();
        ctl_rg = 1'b0;
        set_client(3, 1'b0, 1'b0, 20'h0, 16'h0);
        for (int i = 1; i <= TO - 1; i++) begin
            tick();
            vectors++;
            if ({o_Timeout, o_Busy, o_Client_Data_Valid} !== 6'b010000) begin
                miscompares++;
                $display("FAIL timeout_wait[%0d]: got to=%b busy=%b dv=%b, want 0 1 0000",
                         i, o_Timeout, o_Busy, o_Client_Data_Valid);
            end
        end
        tick();
        vectors++;
        if ({o_Timeout, o_Busy, o_Client_Data_Valid} !== 6'b100000 || o_Read_Data !== 16'h0) begin
            miscompares++;
            $display("FAIL timeout_pulse: got to=%b busy=%b dv=%b data=%h, want 1 0 0000 0000",
                     o_Timeout, o_Busy, o_Client_Data_Valid, o_Read_Data);
        end
        tick();
        vectors++;
        if (o_Timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_single: got %b, want 0", o_Timeout);
        end
        set_client(3, 1'b1, 1'b0, 20'h33333, 16'h0);
        tick();
        ctl_rg = 1'b1;
        tick();
        ctl_rg = 1'b0;
        set_client(3, 1'b0, 1'b0, 20'h0, 16'h0);
        repeat (TO - 2) tick();
        ctl_dv = 1'b1;
        ctl_rdata = 16'h5A5A;
        tick();
        ctl_dv = 1'b0;
        vectors++;
        if (o_Timeout !== 1'b0 || o_Client_Data_Valid !== 4'b1000 || o_Read_Data !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL timeout_dv_wins: got to=%b dv=%b data=%h, want 0 1000 5a5a",
                     o_Timeout, o_Client_Data_Valid, o_Read_Data);
        end
        tick();
    endtask
`else
    task automatic test_timeout();
        do_reset();
        set_client(3, 1'b1, 1'b0, 20'h33333, 16'h0);
        tick();
        ctl_rg = 1'b1;
        tick();
        ctl_rg = 1'b0;
        set_client(3, 1'b0, 1'b0, 20'h0, 16'h0);
        for (int i = 0; i < 4 * TO; i++) begin
            tick();
            vectors++;
            if (o_Timeout !== 1'b0 || o_Busy !== 1'b1) begin
                miscompares++;
                $display("FAIL no_timeout_wait[%0d]: got to=%b busy=%b, want 0 1", i, o_Timeout, o_Busy);
            end
        end
        ctl_dv = 1'b1;
        ctl_rdata = 16'hC0DE;
        tick();
        ctl_dv = 1'b0;
        vectors++;
        if (o_Client_Data_Valid !== 4'b1000 || o_Read_Data !== 16'hC0DE) begin
            miscompares++;
            $display("FAIL no_timeout_dv: got dv=%b data=%h, want 1000 c0de",
                     o_Client_Data_Valid, o_Read_Data);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid_req();
        do_reset();
        set_client(0, 1'b0, 1'b1, 20'h00010, 16'h0010);
        tick();
        ctl_wg = 1'b1;
        tick();
        ctl_wg = 1'b0;
        set_client(0, 1'b0, 1'b0, 20'h0, 16'h0);
        set_client(2, 1'b1, 1'b0, 20'h22222, 16'h0);
        tick();
        vectors++;
        if (o_Ctl_Read_Request !== 1'b1 || o_Ctl_Read_Address !== 20'h22222) begin
            miscompares++;
            $display("FAIL midreset_pre: got rr=%b ra=%h, want 1 22222",
                     o_Ctl_Read_Request, o_Ctl_Read_Address);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_Ctl_Read_Request, o_Ctl_Write_Request, o_Busy, o_Client_Grant, o_Client_Data_Valid,
             o_Read_Data, o_Timeout, o_Ctl_Read_Address, o_Ctl_Write_Address, o_Ctl_Write_Data} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got rr=%b wr=%b busy=%b gnt=%b dv=%b ra=%h, want all 0",
                     o_Ctl_Read_Request, o_Ctl_Write_Request, o_Busy, o_Client_Grant,
                     o_Client_Data_Valid, o_Ctl_Read_Address);
        end
        set_client(0, 1'b0, 1'b1, 20'h0ABCD, 16'hBEEF);
        set_client(1, 1'b0, 1'b1, 20'h11111, 16'h1111);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        vectors++;
        if (o_Ctl_Write_Request !== 1'b1 || o_Ctl_Write_Address !== 20'h0ABCD ||
            o_Ctl_Write_Data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL midreset_priority: got wr=%b wa=%h wd=%h, want 1 0abcd beef",
                     o_Ctl_Write_Request, o_Ctl_Write_Address, o_Ctl_Write_Data);
        end
        ctl_wg = 1'b1;
        tick();
        ctl_wg = 1'b0;
        c_rd = '0;
        c_wr = '0;
        vectors++;
        if (o_Client_Grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL midreset_grant: got %b, want 0001", o_Client_Grant);
        end
        tick();
    endtask

    task automatic test_random();
        int m_phase, m_idx, m_last, m_wait, w, r;
        logic m_write, match, other, exp_to;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_data, exp_rdata;
        logic [NC-1:0] exp_grant, exp_dv;
        logic [1:0] exp_req;
        do_reset();
        m_phase = 0; m_idx = 0; m_last = NC - 1; m_wait = 0;
        m_write = 1'b0; m_addr = '0; m_data = '0; exp_rdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            exp_grant = '0;
            exp_dv = '0;
            exp_to = 1'b0;
            // Advance the model using the inputs that were present at this edge.
            if (m_phase == 0) begin
                w = rr_pick(c_rd | c_wr, m_last);
                if (w >= 0) begin
                    m_idx = w;
                    m_write = c_wr[w];
                    m_addr = c_addr[w*AW +: AW];
                    m_data = c_wdata[w*DW +: DW];
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_write ? ctl_wg : ctl_rg) begin
                    exp_grant = 4'b0001 << m_idx;
                    m_last = m_idx;
                    m_phase = m_write ? 0 : 2;
                    m_wait = 0;
                end
            end else begin
                if (ctl_dv) begin
                    exp_dv = 4'b0001 << m_idx;
                    exp_rdata = ctl_rdata;
                    m_phase = 0;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        exp_to = 1'b1;
                        m_phase = 0;
                    end
                end
`endif
            end
            exp_req = (m_phase == 1) ? {m_write, ~m_write} : 2'b00;

            vectors++;
            if (o_Client_Grant !== exp_grant) begin
                miscompares++;
                $display("FAIL rnd_grant @%0d: got %b, want %b", cyc, o_Client_Grant, exp_grant);
            end
            vectors++;
            if (o_Client_Data_Valid !== exp_dv || o_Read_Data !== exp_rdata) begin
                miscompares++;
                $display("FAIL rnd_data @%0d: got dv=%b data=%h, want dv=%b data=%h",
                         cyc, o_Client_Data_Valid, o_Read_Data, exp_dv, exp_rdata);
            end
            vectors++;
            if ({o_Timeout, o_Busy} !== {exp_to, (m_phase != 0)}) begin
                miscompares++;
                $display("FAIL rnd_status @%0d: got to=%b busy=%b, want to=%b busy=%b",
                         cyc, o_Timeout, o_Busy, exp_to, (m_phase != 0));
            end
            vectors++;
            if ({o_Ctl_Write_Request, o_Ctl_Read_Request} !== exp_req) begin
                miscompares++;
                $display("FAIL rnd_req @%0d: got wr/rd=%b, want %b", cyc,
                         {o_Ctl_Write_Request, o_Ctl_Read_Request}, exp_req);
            end
            if (m_phase == 1) begin
                vectors++;
                if (o_Ctl_Write_Address !== (m_write ? m_addr : '0) ||
                    o_Ctl_Read_Address !== (m_write ? '0 : m_addr) ||
                    (m_write && o_Ctl_Write_Data !== m_data)) begin
                    miscompares++;
                    $display("FAIL rnd_payload @%0d: got wa=%h ra=%h wd=%h, want op=%b addr=%h data=%h",
                             cyc, o_Ctl_Write_Address, o_Ctl_Read_Address, o_Ctl_Write_Data,
                             m_write, m_addr, m_data);
                end
            end

            // Clients: drop on grant, occasionally withdraw while held, raise new requests.
            c_rd &= ~exp_grant;
            c_wr &= ~exp_grant;
            if (m_phase == 1 && $urandom_range(15) == 0) begin
                c_rd[m_idx] = 1'b0;
                c_wr[m_idx] = 1'b0;
            end
            for (int k = 0; k < NC; k++) begin
                if (!c_rd[k] && !c_wr[k] && $urandom_range(3) == 0) begin
                    r = $urandom_range(2);
                    set_client(k, (r != 1), (r != 0), AW'($urandom), DW'($urandom));
                end
            end
            if (m_phase == 1) begin
                match = ($urandom_range(2) == 0);
                other = ($urandom_range(3) == 0);
                ctl_wg = m_write ? match : other;
                ctl_rg = m_write ? other : match;
            end else begin
                ctl_wg = 1'b0;
                ctl_rg = 1'b0;
            end
            ctl_dv = (m_phase == 2) ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
            ctl_rdata = DW'($urandom);
        end
        c_rd = '0; c_wr = '0;
        ctl_wg = 1'b0; ctl_rg = 1'b0; ctl_dv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_return();
        test_round_robin();
        test_simultaneous();
        test_timeout();
        test_reset_mid_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
